// File: rtl/ising_sweep_ctrl.sv
// ising_sweep_ctrl
// Sequencer for Ising-style spin sweeps on an external dot-product tree.
// For each spin k it fetches coupling column k, holds sigma and the column
// steady in front of the tree, samples the local field h_k once the tree
// has settled and sets sigma[k] to sign(h_k) (ties keep the old spin).
// A run repeats full sweeps until the programmed sweep count is reached
// or a sweep produces no flips.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse, accepted only when idle
//   sweeps          maximum sweep count, sampled at start
//   sigma_init      initial spins (1 = +1, 0 = -1), sampled at start
//   busy            high while a run is in progress
//   done            one-cycle pulse at end of run
//   converged       1 when the last completed sweep had no flips
//   flip_count      flips in the most recently completed sweep
//   sigma_out       current spin register
//   col_req_*       coupling-column read request (valid/ready, index)
//   col_rsp_*       single-beat column response, element j at [j*Jw +: Jw]
//   tree_sigma      spins to the tree (same as sigma_out)
//   tree_J_col      registered column to the tree
//   tree_dot        signed tree result
//
// States
//   state  | meaning
//   IDLE   | waiting for start
//   REQ    | column request for spin k held until accepted
//   WAIT   | waiting for the column response beat
//   EVAL   | tree settling; update spin k when the counter reaches zero
//   FIN    | done pulse, back to IDLE
module ising_sweep_ctrl #(
  parameter int VECTOR_SIZE     = 256,
  parameter int J_ELEMENT_WIDTH = 4,
  parameter int DOT_WIDTH       = (J_ELEMENT_WIDTH + 1) + $clog2(VECTOR_SIZE),
  parameter int TREE_LATENCY    = 0,
  parameter int SWEEP_W         = 8,
  parameter int IDX_W           = $clog2(VECTOR_SIZE)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [SWEEP_W-1:0]                     sweeps,
  input  logic [VECTOR_SIZE-1:0]                 sigma_init,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   converged,
  output logic [IDX_W:0]                         flip_count,
  output logic [VECTOR_SIZE-1:0]                 sigma_out,
  output logic                                   col_req_valid,
  input  logic                                   col_req_ready,
  output logic [IDX_W-1:0]                       col_req_idx,
  input  logic                                   col_rsp_valid,
  input  logic [VECTOR_SIZE*J_ELEMENT_WIDTH-1:0] col_rsp_data,
  output logic [VECTOR_SIZE-1:0]                 tree_sigma,
  output logic [VECTOR_SIZE*J_ELEMENT_WIDTH-1:0] tree_J_col,
  input  logic signed [DOT_WIDTH-1:0]            tree_dot
);

  localparam int CNT_W = (TREE_LATENCY > 0) ? $clog2(TREE_LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TREE_LATENCY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EVAL,
    S_FIN
  } state_t;

  state_t                                 r_state;
  state_t                                 w_next_state;
  logic [IDX_W-1:0]                       r_k;
  logic [SWEEP_W-1:0]                     r_sweep_cnt;
  logic [SWEEP_W-1:0]                     r_sweeps;
  logic [VECTOR_SIZE-1:0]                 r_sigma;
  logic [IDX_W:0]                         r_flips;
  logic [IDX_W:0]                         r_flip_count;
  logic                                   r_converged;
  logic [VECTOR_SIZE*J_ELEMENT_WIDTH-1:0] r_jcol;
  logic [CNT_W-1:0]                       r_wcnt;

  logic                                   w_sample;
  logic                                   w_cur_bit;
  logic                                   w_new_bit;
  logic                                   w_dot_neg;
  logic                                   w_dot_zero;
  logic                                   w_flip;
  logic [IDX_W:0]                         w_flips_next;
  logic                                   w_last_spin;
  logic [SWEEP_W-1:0]                     w_sweep_inc;
  logic                                   w_stop;

  assign w_sample     = (r_state == S_EVAL) && (r_wcnt == '0);
  assign w_cur_bit    = r_sigma[r_k];
  assign w_dot_neg    = tree_dot[DOT_WIDTH-1];
  assign w_dot_zero   = (tree_dot == '0);
  // A zero field leaves the spin where it is.
  assign w_new_bit    = w_dot_zero ? w_cur_bit : !w_dot_neg;
  assign w_flip       = w_sample && (w_new_bit != w_cur_bit);
  assign w_flips_next = r_flips + {{IDX_W{1'b0}}, w_flip};
  assign w_last_spin  = (r_k == LAST_IDX);
  assign w_sweep_inc  = r_sweep_cnt + {{(SWEEP_W-1){1'b0}}, 1'b1};
  assign w_stop       = (w_flips_next == '0) || (w_sweep_inc == r_sweeps);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    busy          = 1'b0;
    done          = 1'b0;
    col_req_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (sweeps == '0) ? S_FIN : S_REQ;
        end
      end
      S_REQ: begin
        busy          = 1'b1;
        col_req_valid = 1'b1;
        if (col_req_ready) begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (col_rsp_valid) begin
          w_next_state = S_EVAL;
        end
      end
      S_EVAL: begin
        busy = 1'b1;
        if (r_wcnt == '0) begin
          if (!w_last_spin) begin
            w_next_state = S_REQ;
          end else begin
            w_next_state = w_stop ? S_FIN : S_REQ;
          end
        end
      end
      S_FIN: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k          <= '0;
      r_sweep_cnt  <= '0;
      r_sweeps     <= '0;
      r_sigma      <= '0;
      r_flips      <= '0;
      r_flip_count <= '0;
      r_converged  <= 1'b0;
      r_jcol       <= '0;
      r_wcnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sigma     <= sigma_init;
            r_sweeps    <= sweeps;
            r_k         <= '0;
            r_sweep_cnt <= '0;
            r_flips     <= '0;
            r_converged <= 1'b0;
          end
        end
        S_WAIT: begin
          if (col_rsp_valid) begin
            r_jcol <= col_rsp_data;
            r_wcnt <= CNT_LOAD;
          end
        end
        S_EVAL: begin
          if (r_wcnt != '0) begin
            r_wcnt <= r_wcnt - 1'b1;
          end else begin
            r_sigma[r_k] <= w_new_bit;
            if (!w_last_spin) begin
              r_k     <= r_k + 1'b1;
              r_flips <= w_flips_next;
            end else begin
              // End of sweep: publish the count and rewind to spin 0.
              r_k          <= '0;
              r_flips      <= '0;
              r_flip_count <= w_flips_next;
              r_converged  <= (w_flips_next == '0);
              r_sweep_cnt  <= w_sweep_inc;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sigma_out   = r_sigma;
  assign tree_sigma  = r_sigma;
  assign tree_J_col  = r_jcol;
  assign col_req_idx = r_k;
  assign flip_count  = r_flip_count;
  assign converged   = r_converged;

endmodule

// File: tb/tb_ising_sweep_ctrl.sv
// Bench for ising_sweep_ctrl: two instances (N=4, tree latency 0 and 2),
// each with a behavioural tree and a coupling-memory responder.
module tb_ising_sweep_ctrl;
  localparam int N  = 4;
  localparam int JW = 4;
  localparam int DW = 7;
  localparam int SW = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start [2];
  logic [SW-1:0] sweeps [2];
  logic [N-1:0] sigma_init [2];
  logic busy_w [2];
  logic done_w [2];
  logic conv_w [2];
  logic [IW:0] fc_w [2];
  logic [N-1:0] sig_w [2];
  logic crv_w [2];
  logic crr_w [2];
  logic [IW-1:0] cidx_w [2];
  logic crsv_w [2];
  logic [N*JW-1:0] crsd_w [2];
  logic [N-1:0] tsig_w [2];
  logic [N*JW-1:0] tj_w [2];
  logic signed [DW-1:0] tdot_w [2];

  // jm[g][k][j]: element j of coupling column k for instance g
  logic [JW-1:0] jm [2][N][N];
  int rdy_dly [2];
  int rsp_dly [2];
  logic man [2];
  logic m_ready [2];
  logic m_rsp_v [2];
  logic [N*JW-1:0] m_rsp_d [2];
  int last_fc [2];
  int n_cmp = 0;
  int n_err = 0;

  function automatic int tl(input int g);
    return (g == 0) ? 0 : 2;
  endfunction

  function automatic logic signed [DW-1:0] dotf(input logic [N-1:0] s, input logic [N*JW-1:0] c);
    int acc;
    acc = 0;
    for (int j = 0; j < N; j++) begin
      if (s[j]) acc += int'(c[j*JW +: JW]);
      else      acc -= int'(c[j*JW +: JW]);
    end
    return acc[DW-1:0];
  endfunction

  function automatic logic [N*JW-1:0] colv(input int g, input int k);
    logic [N*JW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*JW +: JW] = jm[g][k][j];
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    logic signed [DW-1:0] dot_c;
    logic signed [DW-1:0] st1;
    logic signed [DW-1:0] st2;
    logic a_ready;
    logic a_rv;
    logic [N*JW-1:0] a_rd;
    int rw;
    int rd;
    bit pend;
    bit hs;
    logic [IW-1:0] hidx;

    ising_sweep_ctrl #(
      .VECTOR_SIZE(N), .J_ELEMENT_WIDTH(JW), .DOT_WIDTH(DW),
      .TREE_LATENCY(g == 0 ? 0 : 2), .SWEEP_W(SW), .IDX_W(IW)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .sweeps(sweeps[g]),
      .sigma_init(sigma_init[g]), .busy(busy_w[g]), .done(done_w[g]),
      .converged(conv_w[g]), .flip_count(fc_w[g]), .sigma_out(sig_w[g]),
      .col_req_valid(crv_w[g]), .col_req_ready(crr_w[g]), .col_req_idx(cidx_w[g]),
      .col_rsp_valid(crsv_w[g]), .col_rsp_data(crsd_w[g]),
      .tree_sigma(tsig_w[g]), .tree_J_col(tj_w[g]), .tree_dot(tdot_w[g])
    );

    always_comb dot_c = dotf(tsig_w[g], tj_w[g]);
    always @(posedge clk) begin
      st1 <= dot_c;
      st2 <= st1;
    end
    if (g == 0) begin : g_comb
      assign tdot_w[g] = dot_c;
    end else begin : g_pipe
      assign tdot_w[g] = st2;
    end

    assign crr_w[g]  = man[g] ? m_ready[g] : a_ready;
    assign crsv_w[g] = man[g] ? m_rsp_v[g] : a_rv;
    assign crsd_w[g] = man[g] ? m_rsp_d[g] : a_rd;

    initial begin
      a_ready = 1'b0; a_rv = 1'b0; a_rd = '0;
      rw = -1; rd = 0; pend = 0; hs = 0; hidx = '0;
    end

    // Memory: ready after rdy_dly cycles of request, response rsp_dly
    // cycles after the cycle following the handshake.
    always @(negedge clk) begin
      a_rv = 1'b0;
      if (man[g]) begin
        a_ready = 1'b0; pend = 0; hs = 0; rw = -1;
      end else begin
        if (hs) begin
          hs = 0; a_ready = 1'b0; pend = 1; rd = rsp_dly[g];
        end
        if (pend) begin
          if (rd == 0) begin
            a_rv = 1'b1;
            a_rd = colv(g, int'(hidx));
            pend = 0;
          end else begin
            rd--;
          end
        end
        if (crv_w[g] && !a_ready) begin
          if (rw < 0) rw = rdy_dly[g];
          if (rw == 0) begin
            a_ready = 1'b1; hs = 1; hidx = cidx_w[g]; rw = -1;
          end else begin
            rw--;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Spin dynamics straight from the rules: sequential sign updates,
  // ties hold, stop on a zero-flip sweep or after sw sweeps.
  function automatic void model(input int g, input logic [N-1:0] s0, input int sw,
                                output logic [N-1:0] sf, output int fc, output bit cv,
                                output int ns);
    int s [N];
    int h, fl, nv;
    for (int j = 0; j < N; j++) s[j] = s0[j] ? 1 : -1;
    fc = 0; ns = 0;
    for (int w = 0; w < sw; w++) begin
      fl = 0;
      for (int k = 0; k < N; k++) begin
        h = 0;
        for (int j = 0; j < N; j++) h += int'(jm[g][k][j]) * s[j];
        nv = (h > 0) ? 1 : (h < 0) ? -1 : s[k];
        if (nv != s[k]) fl++;
        s[k] = nv;
      end
      ns++;
      fc = fl;
      if (fl == 0) break;
    end
    cv = (ns > 0) && (fc == 0);
    for (int j = 0; j < N; j++) sf[j] = (s[j] == 1);
  endfunction

  task automatic start_pulse(input int g, input logic [N-1:0] si, input int sw);
    @(negedge clk);
    sigma_init[g] = si;
    sweeps[g] = SW'(sw);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int g, input int budget,
                           inout int cyc, output bit ok);
    ok = 0;
    while (cyc <= budget) begin
      if (done_w[g]) begin
        ok = 1;
        break;
      end
      chk({tag, "_busy"}, busy_w[g], 1);
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, ok, 1);
  endtask

  task automatic check_end(input string tag, input int g, input logic [N-1:0] esig,
                           input int efc, input bit ecv);
    chk({tag, "_busy_at_done"}, busy_w[g], 0);
    chk({tag, "_sigma"}, sig_w[g], esig);
    chk({tag, "_flips"}, fc_w[g], efc);
    chk({tag, "_conv"}, conv_w[g], ecv);
    last_fc[g] = efc;
    @(negedge clk);
    chk({tag, "_done_pulse"}, done_w[g], 0);
  endtask

  task automatic run_check(input string tag, input int g, input logic [N-1:0] si,
                           input int sw, input bit zw, output int cyc);
    logic [N-1:0] esig;
    int efc, ens;
    bit ecv, ok;
    model(g, si, sw, esig, efc, ecv, ens);
    if (sw == 0) efc = last_fc[g];
    start_pulse(g, si, sw);
    cyc = 1;
    wait_done(tag, g, 3000, cyc, ok);
    if (ok) begin
      if (zw) chk({tag, "_cycles"}, cyc, 1 + ens * N * (3 + tl(g)));
      check_end(tag, g, esig, efc, ecv);
    end
  endtask

  task automatic check_reset(input int g, input string tag);
    chk({tag, "_busy"}, busy_w[g], 0);
    chk({tag, "_done"}, done_w[g], 0);
    chk({tag, "_conv"}, conv_w[g], 0);
    chk({tag, "_flips"}, fc_w[g], 0);
    chk({tag, "_sigma"}, sig_w[g], 0);
    chk({tag, "_req_valid"}, crv_w[g], 0);
    chk({tag, "_req_idx"}, cidx_w[g], 0);
    chk({tag, "_jcol"}, tj_w[g], 0);
  endtask

  task automatic load_uniform(input int g);
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) jm[g][k][j] = (k == j) ? 4'd0 : 4'd1;
  endtask

  initial begin
    int cyc, t, sw, g;
    bit zw, ok;
    logic [N-1:0] si;
    logic [N-1:0] esig;
    int efc, ens;
    bit ecv;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; sweeps[i] = '0; sigma_init[i] = '0;
      man[i] = 1'b0; m_ready[i] = 1'b0; m_rsp_v[i] = 1'b0; m_rsp_d[i] = '0;
      rdy_dly[i] = 0; rsp_dly[i] = 0; last_fc[i] = 0;
      for (int k = 0; k < N; k++)
        for (int j = 0; j < N; j++) jm[i][k][j] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset(0, "rst0_u0");
    check_reset(1, "rst0_u1");

    // Uniform ferromagnet: bit 3 flips in sweep 1, sweep 2 is quiet.
    load_uniform(0);
    run_check("tp1", 0, 4'b0111, 5, 1, cyc);
    chk("tp1_cyc_const", cyc, 25);
    chk("tp1_sigma_const", sig_w[0], 4'b1111);
    chk("tp1_conv_const", conv_w[0], 1);
    chk("tp1_flips_const", fc_w[0], 0);

    // Tie on spin 0 must keep the spin either way.
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) jm[0][k][j] = '0;
    jm[0][0][1] = 4'd1;
    jm[0][0][2] = 4'd1;
    run_check("tie_a", 0, 4'b0010, 1, 1, cyc);
    chk("tie_a_sigma_const", sig_w[0], 4'b0010);
    chk("tie_a_flips_const", fc_w[0], 0);
    run_check("tie_b", 0, 4'b0011, 1, 1, cyc);
    chk("tie_b_sigma_const", sig_w[0], 4'b0011);

    // One flip sweep so flip_count is nonzero, then sweeps=0 must keep it.
    load_uniform(0);
    run_check("one_sweep", 0, 4'b0111, 1, 1, cyc);
    chk("one_sweep_flips_const", fc_w[0], 1);
    run_check("sw0", 0, 4'b1010, 0, 1, cyc);
    chk("sw0_cyc_const", cyc, 1);
    chk("sw0_flips_kept", fc_w[0], 1);

    // Tree latency 2: 5 cycles per spin, 20 per sweep.
    load_uniform(1);
    run_check("lat2", 1, 4'b0111, 1, 1, cyc);
    chk("lat2_cyc_const", cyc, 21);
    chk("lat2_sigma_const", sig_w[1], 4'b1111);

    // Backpressure on request and a late response, driven by hand.
    load_uniform(0);
    man[0] = 1'b1;
    model(0, 4'b0001, 1, esig, efc, ecv, ens);
    start_pulse(0, 4'b0001, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_valid", crv_w[0], 1);
      chk("bp_req_idx", cidx_w[0], 0);
      @(negedge clk);
    end
    m_ready[0] = 1'b1;
    @(negedge clk);
    m_ready[0] = 1'b0;
    chk("bp_req_dropped", crv_w[0], 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_sigma_hold", sig_w[0], 4'b0001);
      chk("bp_busy", busy_w[0], 1);
      @(negedge clk);
    end
    m_rsp_v[0] = 1'b1;
    m_rsp_d[0] = colv(0, 0);
    @(negedge clk);
    m_rsp_v[0] = 1'b0;
    chk("bp_sigma_eval", sig_w[0], 4'b0001);
    chk("bp_jcol", tj_w[0], colv(0, 0));
    man[0] = 1'b0;
    cyc = 0;
    wait_done("bp", 0, 200, cyc, ok);
    if (ok) check_end("bp", 0, esig, efc, ecv);

    // Reset in the WAIT of spin 2, then a stale response.
    man[0] = 1'b1;
    start_pulse(0, 4'b0101, 3);
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (!crv_w[0] && t < 10) begin
        @(negedge clk);
        t++;
      end
      chk("mid_req_seen", crv_w[0], 1);
      chk("mid_req_idx", cidx_w[0], k);
      m_ready[0] = 1'b1;
      @(negedge clk);
      m_ready[0] = 1'b0;
      if (k < 2) begin
        m_rsp_v[0] = 1'b1;
        m_rsp_d[0] = colv(0, k);
        @(negedge clk);
        m_rsp_v[0] = 1'b0;
      end
    end
    chk("mid_busy_before_rst", busy_w[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset(0, "mid_rst");
    last_fc[0] = 0;
    last_fc[1] = 0;
    m_rsp_v[0] = 1'b1;
    m_rsp_d[0] = colv(0, 2);
    @(negedge clk);
    m_rsp_v[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stale_busy", busy_w[0], 0);
      chk("stale_req", crv_w[0], 0);
      chk("stale_jcol", tj_w[0], 0);
      chk("stale_sigma", sig_w[0], 0);
      @(negedge clk);
    end
    man[0] = 1'b0;
    run_check("rerun", 0, 4'b0101, 3, 1, cyc);

    // Random couplings, spins, sweep counts and memory timing.
    for (int it = 0; it < 14; it++) begin
      g = it % 2;
      for (int k = 0; k < N; k++)
        for (int j = 0; j < N; j++)
          jm[g][k][j] = (k == j) ? 4'd0 : JW'($urandom_range(0, 15));
      zw = ((it % 4) < 2);
      rdy_dly[g] = zw ? 0 : int'($urandom_range(0, 3));
      rsp_dly[g] = zw ? 0 : int'($urandom_range(0, 3));
      si = N'($urandom_range(0, 15));
      sw = int'($urandom_range(1, 6));
      run_check($sformatf("rnd%0d", it), g, si, sw, zw, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
